rf_hazard_ctrl: RTL and testbench

Sequences the 2-read/1-write integer register file (x0 hardwired zero, 1-cycle registered reads) for the in-order core. Holds a per-register scoreboard of pending long-latency results (load, mul/div) and stalls issue on RAW and WAW hazards against them. Drives the read enables and addresses. Arbitrates the single write port between the fast (ALU) writeback and a buffered slow (LSU/MDU) writeback, with anti-starvation.

---
 rtl/rf_hazard_ctrl_pkg.sv | 25 ++
 rtl/rf_wb_fifo.sv | 63 ++++++
 rtl/rf_hazard_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rf_hazard_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_hazard_ctrl_pkg.sv
// Shared constants and types for the register-file hazard controller.
package rf_hazard_ctrl_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;
   localparam int NREGS  = 32;

   // Which source owns the single regfile write port this cycle.
   typedef enum logic [2:0] {
      WB_SRC_NONE   = 3'd0,
      WB_SRC_STARVE = 3'd1,
      WB_SRC_FAST   = 3'd2,
      WB_SRC_FIFO   = 3'd3,
      WB_SRC_BYPASS = 3'd4
   } wb_src_e;

   // One-hot mask selecting a single architectural register.
   function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] idx);
      logic [NREGS-1:0] v;
      v      = {NREGS{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering slow-unit writebacks {rd, data}.
// Push and pop may happen in the same cycle; the head is read combinationally.
module rf_wb_fifo #(
   parameter int W     = 69,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty
);
   import rf_hazard_ctrl_pkg::*;

   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   cnt_r;
   logic          push_s;
   logic          pop_s;

   // Never write past a full buffer or read from an empty one.
   assign push_s   = push & ~full;
   assign pop_s    = pop & ~empty;
   assign full     = (cnt_r == FULL_CNT);
   assign empty    = (cnt_r == {(AW+1){1'b0}});
   assign head_dat = mem_r[rd_ptr_r];

   // Storage array; contents need no reset because the count gates visibility.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_dat;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         cnt_r    <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
            2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/rf_hazard_ctrl.sv
// Register-file sequencer for the in-order core: scoreboard of pending
// long-latency results with RAW/WAW issue stall, read-port drive, and
// arbitration of the single write port between fast and buffered slow
// writebacks with a starvation guard for the slow buffer.
module rf_hazard_ctrl #(
   parameter int XLEN       = rf_hazard_ctrl_pkg::XLEN,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_issue_valid,
   input  logic                                  i_issue_rs1_re,
   input  logic                                  i_issue_rs2_re,
   input  logic [rf_hazard_ctrl_pkg::REG_AW-1:0] i_issue_rs1_addr,
   input  logic [rf_hazard_ctrl_pkg::REG_AW-1:0] i_issue_rs2_addr,
   input  logic                                  i_issue_rd_we,
   input  logic [rf_hazard_ctrl_pkg::REG_AW-1:0] i_issue_rd,
   input  logic                                  i_issue_long,
   output logic                                  o_issue_ready,
   output logic                                  o_rs1_re,
   output logic                                  o_rs2_re,
   output logic [rf_hazard_ctrl_pkg::REG_AW-1:0] o_rs1_addr,
   output logic [rf_hazard_ctrl_pkg::REG_AW-1:0] o_rs2_addr,
   input  logic                                  i_wb0_valid,
   input  logic [rf_hazard_ctrl_pkg::REG_AW-1:0] i_wb0_rd,
   input  logic [XLEN-1:0]                       i_wb0_dat,
   output logic                                  o_wb0_ready,
   input  logic                                  i_wb1_valid,
   input  logic [rf_hazard_ctrl_pkg::REG_AW-1:0] i_wb1_rd,
   input  logic [XLEN-1:0]                       i_wb1_dat,
   output logic                                  o_wb1_ready,
   output logic                                  o_rf_we,
   output logic [rf_hazard_ctrl_pkg::REG_AW-1:0] o_rd,
   output logic [XLEN-1:0]                       o_rd_dat,
   output logic [rf_hazard_ctrl_pkg::NREGS-1:0]  o_busy,
   output logic                                  o_err
);
   import rf_hazard_ctrl_pkg::*;

   localparam int              SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
   localparam int              EW         = REG_AW + XLEN;
   localparam logic [NREGS-1:0] X0_KEEP   = {{(NREGS-1){1'b1}}, 1'b0};

   logic [NREGS-1:0]  busy_r;
   logic [NREGS-1:0]  busy_nxt_s;
   logic [NREGS-1:0]  set_mask_s;
   logic [NREGS-1:0]  clr_mask_s;
   logic [SW-1:0]     starve_r;
   logic [SW-1:0]     starve_nxt_s;
   logic              err_r;
   logic              err_nxt_s;
   logic              haz_s;
   logic              fire_s;
   logic              long_set_s;
   logic              starve_hit_s;
   wb_src_e           wb_src_s;
   logic              fifo_push_s;
   logic              fifo_pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [EW-1:0]     fifo_head_s;
   logic [REG_AW-1:0] head_rd_s;
   logic [XLEN-1:0]   head_dat_s;
   logic              slow_we_s;
   logic              fast_win_s;

   // Hazard check uses only the registered scoreboard, so a clear becomes
   // visible the cycle after the regfile write, matching regfile read timing.
   assign haz_s = (i_issue_rs1_re & busy_r[i_issue_rs1_addr])
                | (i_issue_rs2_re & busy_r[i_issue_rs2_addr])
                | (i_issue_rd_we  & busy_r[i_issue_rd]);

   assign o_issue_ready = ~haz_s;
   assign fire_s        = i_issue_valid & ~haz_s;
   assign long_set_s    = fire_s & i_issue_rd_we & i_issue_long & (i_issue_rd != {REG_AW{1'b0}});
   assign o_rs1_re      = fire_s & i_issue_rs1_re;
   assign o_rs2_re      = fire_s & i_issue_rs2_re;
   assign o_rs1_addr    = i_issue_rs1_addr;
   assign o_rs2_addr    = i_issue_rs2_addr;

   assign o_busy = busy_r;
   assign o_err  = err_r;

   // Slow writeback buffer.
   rf_wb_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_wb_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push_s),
      .push_dat ({i_wb1_rd, i_wb1_dat}),
      .pop      (fifo_pop_s),
      .head_dat (fifo_head_s),
      .full     (fifo_full_s),
      .empty    (fifo_empty_s)
   );

   assign head_rd_s  = fifo_head_s[EW-1:XLEN];
   assign head_dat_s = fifo_head_s[XLEN-1:0];

   // A buffered slow result that has lost too often takes the port from wb0.
   assign starve_hit_s = ~fifo_empty_s & (starve_r == STARVE_LIM);
   assign o_wb0_ready  = ~starve_hit_s;
   assign o_wb1_ready  = ~fifo_full_s;

   // Write-port priority: starved head, fast path, buffered head, bypass.
   always_comb begin
      wb_src_s = WB_SRC_NONE;
      if (starve_hit_s) begin
         wb_src_s = WB_SRC_STARVE;
      end else if (i_wb0_valid) begin
         wb_src_s = WB_SRC_FAST;
      end else if (!fifo_empty_s) begin
         wb_src_s = WB_SRC_FIFO;
      end else if (i_wb1_valid) begin
         wb_src_s = WB_SRC_BYPASS;
      end else begin
         wb_src_s = WB_SRC_NONE;
      end
   end

   // Drive the regfile write port from the winning source.
   always_comb begin
      o_rf_we    = 1'b0;
      o_rd       = {REG_AW{1'b0}};
      o_rd_dat   = {XLEN{1'b0}};
      fifo_pop_s = 1'b0;
      slow_we_s  = 1'b0;
      fast_win_s = 1'b0;
      case (wb_src_s)
         WB_SRC_STARVE, WB_SRC_FIFO: begin
            o_rf_we    = 1'b1;
            o_rd       = head_rd_s;
            o_rd_dat   = head_dat_s;
            fifo_pop_s = 1'b1;
            slow_we_s  = 1'b1;
         end
         WB_SRC_FAST: begin
            o_rf_we    = 1'b1;
            o_rd       = i_wb0_rd;
            o_rd_dat   = i_wb0_dat;
            fast_win_s = 1'b1;
         end
         WB_SRC_BYPASS: begin
            o_rf_we    = 1'b1;
            o_rd       = i_wb1_rd;
            o_rd_dat   = i_wb1_dat;
            slow_we_s  = 1'b1;
         end
         default: begin
            o_rf_we    = 1'b0;
         end
      endcase
   end

   // Accepted slow writebacks are buffered unless they went straight to the port.
   assign fifo_push_s = i_wb1_valid & ~fifo_full_s & (wb_src_s != WB_SRC_BYPASS);

   // Count consecutive losses of a non-empty buffer to wb0, saturating.
   always_comb begin
      starve_nxt_s = starve_r;
      if (fifo_empty_s || fifo_pop_s) begin
         starve_nxt_s = {SW{1'b0}};
      end else if (fast_win_s && (starve_r != STARVE_LIM)) begin
         starve_nxt_s = starve_r + SW'(1);
      end else begin
         starve_nxt_s = starve_r;
      end
   end

   // Scoreboard update and sticky protocol-error detection.
   always_comb begin
      set_mask_s = {NREGS{1'b0}};
      clr_mask_s = {NREGS{1'b0}};
      if (long_set_s) begin
         set_mask_s = reg_onehot(i_issue_rd);
      end else begin
         set_mask_s = {NREGS{1'b0}};
      end
      if (slow_we_s) begin
         clr_mask_s = reg_onehot(o_rd);
      end else begin
         clr_mask_s = {NREGS{1'b0}};
      end
      busy_nxt_s = (busy_r | set_mask_s) & ~clr_mask_s & X0_KEEP;
      err_nxt_s  = err_r
                 | (slow_we_s & (o_rd != {REG_AW{1'b0}}) & ~busy_r[o_rd])
                 | (long_set_s & busy_r[i_issue_rd])
                 | (i_wb0_valid & busy_r[i_wb0_rd]);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r   <= {NREGS{1'b0}};
         starve_r <= {SW{1'b0}};
         err_r    <= 1'b0;
      end else begin
         busy_r   <= busy_nxt_s;
         starve_r <= starve_nxt_s;
         err_r    <= err_nxt_s;
      end
   end

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Self-checking bench for rf_hazard_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_rf_hazard_ctrl;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_issue_valid, i_issue_rs1_re, i_issue_rs2_re;
   logic [4:0]      i_issue_rs1_addr, i_issue_rs2_addr, i_issue_rd;
   logic            i_issue_rd_we, i_issue_long;
   logic            o_issue_ready, o_rs1_re, o_rs2_re;
   logic [4:0]      o_rs1_addr, o_rs2_addr;
   logic            i_wb0_valid, o_wb0_ready, i_wb1_valid, o_wb1_ready;
   logic [4:0]      i_wb0_rd, i_wb1_rd, o_rd;
   logic [XLEN-1:0] i_wb0_dat, i_wb1_dat, o_rd_dat;
   logic            o_rf_we, o_err;
   logic [31:0]     o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_hazard_ctrl #(.XLEN(XLEN), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .i_issue_valid(i_issue_valid), .i_issue_rs1_re(i_issue_rs1_re), .i_issue_rs2_re(i_issue_rs2_re),
      .i_issue_rs1_addr(i_issue_rs1_addr), .i_issue_rs2_addr(i_issue_rs2_addr),
      .i_issue_rd_we(i_issue_rd_we), .i_issue_rd(i_issue_rd), .i_issue_long(i_issue_long),
      .o_issue_ready(o_issue_ready), .o_rs1_re(o_rs1_re), .o_rs2_re(o_rs2_re),
      .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
      .i_wb0_valid(i_wb0_valid), .i_wb0_rd(i_wb0_rd), .i_wb0_dat(i_wb0_dat), .o_wb0_ready(o_wb0_ready),
      .i_wb1_valid(i_wb1_valid), .i_wb1_rd(i_wb1_rd), .i_wb1_dat(i_wb1_dat), .o_wb1_ready(o_wb1_ready),
      .o_rf_we(o_rf_we), .o_rd(o_rd), .o_rd_dat(o_rd_dat), .o_busy(o_busy), .o_err(o_err)
   );

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic r1e, input logic [4:0] r1, input logic r2e,
                        input logic [4:0] r2, input logic we, input logic [4:0] rd, input logic lng);
      i_issue_valid = v; i_issue_rs1_re = r1e; i_issue_rs1_addr = r1; i_issue_rs2_re = r2e;
      i_issue_rs2_addr = r2; i_issue_rd_we = we; i_issue_rd = rd; i_issue_long = lng;
   endtask

   task automatic set_wb0(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
      i_wb0_valid = v; i_wb0_rd = rd; i_wb0_dat = d;
   endtask

   task automatic set_wb1(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
      i_wb1_valid = v; i_wb1_rd = rd; i_wb1_dat = d;
   endtask

   task automatic idle_inputs();
      issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      set_wb0(1'b0, 5'd0, 64'd0);
      set_wb1(1'b0, 5'd0, 64'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (o_busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=%h", o_busy, 32'h0); end
      n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", o_err); end
      n_checks++; if (o_wb0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb0_ready got=%b exp=1", o_wb0_ready); end
      n_checks++; if (o_wb1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb1_ready got=%b exp=1", o_wb1_ready); end
      n_checks++; if (o_rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got=%b exp=0", o_rf_we); end
      n_checks++; if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", o_issue_ready); end
      cyc();
   endtask

   task automatic test_raw_stall();
      issue(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);   // ld x5, 0(x1)
      @(negedge clk);
      n_checks++; if (o_issue_ready !== 1'b1 || o_rs1_re !== 1'b1 || o_rs1_addr !== 5'd1) begin
         n_fail++; $display("FAIL raw_ld_issue got ready=%b re=%b addr=%0d exp 1 1 1", o_issue_ready, o_rs1_re, o_rs1_addr); end
      cyc();
      issue(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0);   // add x6, x5, x1
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (o_issue_ready !== 1'b0 || o_rs1_re !== 1'b0) begin
            n_fail++; $display("FAIL raw_stall[%0d] got ready=%b re=%b exp 0 0", i, o_issue_ready, o_rs1_re); end
         cyc();
      end
      set_wb1(1'b1, 5'd5, 64'h55);
      @(negedge clk);
      n_checks++; if (o_issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_wb got ready=%b exp=0", o_issue_ready); end
      n_checks++; if (o_rf_we !== 1'b1 || o_rd !== 5'd5 || o_rd_dat !== 64'h55) begin
         n_fail++; $display("FAIL raw_bypass_write got we=%b rd=%0d dat=%h exp 1 5 55", o_rf_we, o_rd, o_rd_dat); end
      n_checks++; if (o_busy !== 32'h20) begin n_fail++; $display("FAIL raw_busy_set got=%h exp=%h", o_busy, 32'h20); end
      cyc();
      set_wb1(1'b0, 5'd0, 64'd0);
      @(negedge clk);
      n_checks++; if (o_issue_ready !== 1'b1 || o_rs1_re !== 1'b1 || o_rs1_addr !== 5'd5 || o_rs2_re !== 1'b1) begin
         n_fail++; $display("FAIL raw_release got ready=%b re1=%b addr1=%0d re2=%b exp 1 1 5 1", o_issue_ready, o_rs1_re, o_rs1_addr, o_rs2_re); end
      n_checks++; if (o_busy !== 32'h0 || o_err !== 1'b0) begin
         n_fail++; $display("FAIL raw_after got busy=%h err=%b exp 0 0", o_busy, o_err); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_x0();
      issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);   // long op into x0
      @(negedge clk);
      n_checks++; if (o_issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_issue got ready=%b exp=1", o_issue_ready); end
      cyc();
      issue(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b0);
      @(negedge clk);
      n_checks++; if (o_busy !== 32'h0) begin n_fail++; $display("FAIL x0_busy got=%h exp=0", o_busy); end
      n_checks++; if (o_issue_ready !== 1'b1 || o_rs1_re !== 1'b1) begin
         n_fail++; $display("FAIL x0_reader got ready=%b re=%b exp 1 1", o_issue_ready, o_rs1_re); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_same_cycle();
      issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
      cyc();
      idle_inputs();
      set_wb0(1'b1, 5'd7, 64'h77);
      set_wb1(1'b1, 5'd5, 64'h55);
      @(negedge clk);
      n_checks++; if (o_rf_we !== 1'b1 || o_rd !== 5'd7 || o_rd_dat !== 64'h77) begin
         n_fail++; $display("FAIL same_fast got we=%b rd=%0d dat=%h exp 1 7 77", o_rf_we, o_rd, o_rd_dat); end
      n_checks++; if (o_wb0_ready !== 1'b1 || o_wb1_ready !== 1'b1) begin
         n_fail++; $display("FAIL same_ready got r0=%b r1=%b exp 1 1", o_wb0_ready, o_wb1_ready); end
      cyc();
      idle_inputs();
      @(negedge clk);
      n_checks++; if (o_rf_we !== 1'b1 || o_rd !== 5'd5 || o_rd_dat !== 64'h55) begin
         n_fail++; $display("FAIL same_drain got we=%b rd=%0d dat=%h exp 1 5 55", o_rf_we, o_rd, o_rd_dat); end
      n_checks++; if (o_busy !== 32'h20) begin n_fail++; $display("FAIL same_busy_hold got=%h exp=%h", o_busy, 32'h20); end
      cyc();
      @(negedge clk);
      n_checks++; if (o_busy !== 32'h0 || o_rf_we !== 1'b0) begin
         n_fail++; $display("FAIL same_busy_clr got busy=%h we=%b exp 0 0", o_busy, o_rf_we); end
      cyc();
   endtask

   task automatic test_starve();
      logic [4:0] r;
      logic [4:0] er;
      issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
      cyc();
      idle_inputs();
      for (int i = 0; i < 7; i++) begin
         r  = (i < 6) ? 5'(10 + i) : 5'd15;
         er = (i == 5) ? 5'd5 : r;
         set_wb0(1'b1, r, 64'h1000 + 64'(r));
         set_wb1(i == 0, 5'd5, 64'h55);
         @(negedge clk);
         n_checks++; if (o_wb0_ready !== (i != 5)) begin
            n_fail++; $display("FAIL starve_wb0_ready[%0d] got=%b exp=%b", i, o_wb0_ready, (i != 5)); end
         n_checks++; if (o_rf_we !== 1'b1 || o_rd !== er) begin
            n_fail++; $display("FAIL starve_write[%0d] got we=%b rd=%0d exp 1 %0d", i, o_rf_we, o_rd, er); end
         cyc();
      end
      idle_inputs();
      @(negedge clk);
      n_checks++; if (o_busy !== 32'h0 || o_rf_we !== 1'b0) begin
         n_fail++; $display("FAIL starve_end got busy=%h we=%b exp 0 0", o_busy, o_rf_we); end
      cyc();
   endtask

   task automatic test_fifo_full();
      logic [4:0]  w0rd [10];
      logic [4:0]  w1rd [10];
      logic [4:0]  exprd [10];
      logic [9:0]  vld, e0r, e1r, ewe, slow;
      logic [XLEN-1:0] edat;
      w0rd  = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd16, 5'd0, 5'd0, 5'd0};
      w1rd  = '{5'd5, 5'd6, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd0, 5'd0, 5'd0};
      exprd = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd5, 5'd16, 5'd6, 5'd8, 5'd0};
      vld   = 10'b0001111111;
      e0r   = 10'b1111011111;
      e1r   = 10'b1101000011;
      ewe   = 10'b0111111111;
      slow  = 10'b0110100000;
      issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1); cyc();
      issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b1); cyc();
      issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1); cyc();
      idle_inputs();
      for (int s = 0; s < 10; s++) begin
         set_wb0(vld[s], w0rd[s], 64'h1000 + 64'(w0rd[s]));
         set_wb1(vld[s], w1rd[s], 64'hA000 + 64'(w1rd[s]));
         edat = slow[s] ? 64'hA000 + 64'(exprd[s]) : 64'h1000 + 64'(exprd[s]);
         @(negedge clk);
         n_checks++; if (o_wb0_ready !== e0r[s] || o_wb1_ready !== e1r[s]) begin
            n_fail++; $display("FAIL full_ready[%0d] got r0=%b r1=%b exp %b %b", s, o_wb0_ready, o_wb1_ready, e0r[s], e1r[s]); end
         n_checks++; if (o_rf_we !== ewe[s] || (ewe[s] && (o_rd !== exprd[s] || o_rd_dat !== edat))) begin
            n_fail++; $display("FAIL full_write[%0d] got we=%b rd=%0d dat=%h exp %b %0d %h", s, o_rf_we, o_rd, o_rd_dat, ewe[s], exprd[s], edat); end
         cyc();
      end
      @(negedge clk);
      n_checks++; if (o_busy !== 32'h0 || o_err !== 1'b0) begin
         n_fail++; $display("FAIL full_end got busy=%h err=%b exp 0 0", o_busy, o_err); end
      cyc();
   endtask

   task automatic test_err_and_reset();
      set_wb1(1'b1, 5'd9, 64'h99);
      @(negedge clk);
      n_checks++; if (o_rf_we !== 1'b1 || o_rd !== 5'd9 || o_err !== 1'b0) begin
         n_fail++; $display("FAIL err_write got we=%b rd=%0d err=%b exp 1 9 0", o_rf_we, o_rd, o_err); end
      cyc();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky[%0d] got=%b exp=1", i, o_err); end
         cyc();
      end
      issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
      cyc();
      idle_inputs();
      set_wb0(1'b1, 5'd12, 64'h12);
      set_wb1(1'b1, 5'd5, 64'h55);
      cyc();
      idle_inputs();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (o_rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_no_write got=%b exp=0", o_rf_we); end
      n_checks++; if (o_busy !== 32'h0 || o_err !== 1'b0 || o_wb1_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_state got busy=%h err=%b r1=%b exp 0 0 1", o_busy, o_err, o_wb1_ready); end
      cyc();
   endtask

   task automatic test_random();
      bit              m_busy [32];
      logic [68:0]     m_q [$];
      int              pend [$];
      int              m_starve;
      bit              m_err;
      bit              haz, fire, shit, acc1, e_wb0r, e_wb1r, e_we, slow_w, fast_w, popq, byp;
      logic [4:0]      e_rd;
      logic [XLEN-1:0] e_dat;
      logic [31:0]     e_busy;
      int              qn, pi;
      rst = 1'b1; idle_inputs(); cyc(); rst = 1'b0;
      for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
      m_q.delete(); pend.delete(); m_starve = 0; m_err = 1'b0;
      for (int c = 0; c < 600; c++) begin
         issue(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         set_wb0(1'($urandom_range(0, 3) < 3), 5'($urandom_range(0, 31)), {$urandom, $urandom});
         if (m_busy[i_wb0_rd]) i_wb0_valid = 1'b0;
         pi = (pend.size() > 0) ? int'($urandom_range(0, pend.size() - 1)) : 0;
         set_wb1((pend.size() > 0) && ($urandom_range(0, 1) == 1), (pend.size() > 0) ? 5'(pend[pi]) : 5'd0,
                 {$urandom, $urandom});
         // Expected behaviour from the current model state.
         qn     = m_q.size();
         haz    = (i_issue_rs1_re && m_busy[i_issue_rs1_addr]) || (i_issue_rs2_re && m_busy[i_issue_rs2_addr])
                || (i_issue_rd_we && m_busy[i_issue_rd]);
         fire   = i_issue_valid && !haz;
         shit   = (qn > 0) && (m_starve >= 4);
         e_wb0r = !shit;
         e_wb1r = (qn < 2);
         acc1   = i_wb1_valid && e_wb1r;
         e_we = 1'b0; e_rd = 5'd0; e_dat = 64'd0; slow_w = 1'b0; fast_w = 1'b0; popq = 1'b0; byp = 1'b0;
         if (shit || (!i_wb0_valid && qn > 0)) begin
            e_we = 1'b1; e_rd = m_q[0][68:64]; e_dat = m_q[0][63:0]; slow_w = 1'b1; popq = 1'b1;
         end else if (i_wb0_valid) begin
            e_we = 1'b1; e_rd = i_wb0_rd; e_dat = i_wb0_dat; fast_w = 1'b1;
         end else if (acc1) begin
            e_we = 1'b1; e_rd = i_wb1_rd; e_dat = i_wb1_dat; slow_w = 1'b1; byp = 1'b1;
         end
         for (int k = 0; k < 32; k++) e_busy[k] = m_busy[k];
         @(negedge clk);
         n_checks++; if (o_issue_ready !== !haz || o_rs1_re !== (fire && i_issue_rs1_re) || o_rs2_re !== (fire && i_issue_rs2_re)) begin
            n_fail++; $display("FAIL rnd_issue[%0d] got rdy=%b re1=%b re2=%b exp %b %b %b", c, o_issue_ready, o_rs1_re, o_rs2_re,
                               !haz, fire && i_issue_rs1_re, fire && i_issue_rs2_re); end
         n_checks++; if (o_rs1_addr !== i_issue_rs1_addr || o_rs2_addr !== i_issue_rs2_addr) begin
            n_fail++; $display("FAIL rnd_addr[%0d] got %0d %0d exp %0d %0d", c, o_rs1_addr, o_rs2_addr, i_issue_rs1_addr, i_issue_rs2_addr); end
         n_checks++; if (o_wb0_ready !== e_wb0r || o_wb1_ready !== e_wb1r) begin
            n_fail++; $display("FAIL rnd_ready[%0d] got r0=%b r1=%b exp %b %b", c, o_wb0_ready, o_wb1_ready, e_wb0r, e_wb1r); end
         n_checks++; if (o_rf_we !== e_we || (e_we && (o_rd !== e_rd || o_rd_dat !== e_dat))) begin
            n_fail++; $display("FAIL rnd_write[%0d] got we=%b rd=%0d dat=%h exp %b %0d %h", c, o_rf_we, o_rd, o_rd_dat, e_we, e_rd, e_dat); end
         n_checks++; if (o_busy !== e_busy || o_err !== m_err) begin
            n_fail++; $display("FAIL rnd_state[%0d] got busy=%h err=%b exp %h %b", c, o_busy, o_err, e_busy, m_err); end
         // Advance the model.
         if (slow_w && e_rd != 5'd0 && !m_busy[e_rd]) m_err = 1'b1;
         if (fire && i_issue_rd_we && i_issue_long && i_issue_rd != 5'd0 && m_busy[i_issue_rd]) m_err = 1'b1;
         if (i_wb0_valid && m_busy[i_wb0_rd]) m_err = 1'b1;
         if (qn == 0 || popq) m_starve = 0;
         else if (fast_w) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
         if (slow_w) m_busy[e_rd] = 1'b0;
         if (fire && i_issue_rd_we && i_issue_long && i_issue_rd != 5'd0) begin
            m_busy[i_issue_rd] = 1'b1;
            pend.push_back(int'(i_issue_rd));
         end
         if (popq) void'(m_q.pop_front());
         if (acc1) begin
            pend.delete(pi);
            if (!byp) m_q.push_back({i_wb1_rd, i_wb1_dat});
         end
         cyc();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_raw_stall();
      test_x0();
      test_same_cycle();
      test_starve();
      test_fifo_full();
      test_err_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
